// File: rtl/sr_cmd_pkg.sv
// Shared types and constants for the SR command sequencer slice.
package sr_cmd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic PRIO_RESET = 1'b1;
  localparam logic PRIO_SET   = 1'b0;

  // Wide enough for DEBOUNCE and GAP up to 255.
  localparam int CNT_W = 8;

endpackage

// File: rtl/sr_cmd_sequencer_if.sv
// Request/command bundle between a request source and the SR command sequencer.
interface sr_cmd_sequencer_if;

  logic set_req;
  logic rst_req;
  logic s;
  logic r;
  logic busy;
  logic shadow_q;
  logic conflict;
  logic dropped;

  modport master (
    output set_req, rst_req,
    input  s, r, busy, shadow_q, conflict, dropped
  );

  modport slave (
    input  set_req, rst_req,
    output s, r, busy, shadow_q, conflict, dropped
  );

endinterface

// File: rtl/sr_sync_debounce.sv
// Synchroniser plus debouncer for one raw request line; flags the edge on which
// the debounced level rises.
module sr_sync_debounce
  import sr_cmd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic [CNT_W-1:0]       cnt;
  logic                   level;
  logic                   synced;
  logic                   flip;

  assign synced = sync_ff[SYNC_STAGES-1];
  assign flip   = (synced != level) && (cnt == CNT_W'(DEBOUNCE - 1));
  // Combinational so the pending bit upstream captures it on the flip edge itself.
  assign rise   = flip && synced;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync_ff <= '0;
      level   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], raw};
      if (synced == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= synced;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Turns debounced set/reset requests into mutually exclusive, spaced s/r pulses
// for a downstream SR flip-flop and tracks that flip-flop's expected state.
module sr_cmd_sequencer
  import sr_cmd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int GAP         = 2,
  parameter bit RESET_PRIO  = 1'b1
) (
  input logic              clk,
  input logic              clr,
  sr_cmd_sequencer_if.slave bus
);

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic             pend_set;
  logic             pend_rst;
  logic             rise_set;
  logic             rise_rst;
  logic             serve_set;
  logic             serve_rst;
  logic             pend_set_nxt;
  logic             pend_rst_nxt;
  logic             s_q;
  logic             r_q;
  logic             busy_q;
  logic             shadow_q;
  logic             conflict_q;
  logic             dropped_q;

  sr_sync_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE    (DEBOUNCE)
  ) u_set_line (
    .clk  (clk),
    .clr  (clr),
    .raw  (bus.set_req),
    .rise (rise_set)
  );

  sr_sync_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE    (DEBOUNCE)
  ) u_rst_line (
    .clk  (clk),
    .clr  (clr),
    .raw  (bus.rst_req),
    .rise (rise_rst)
  );

  always_comb begin
    serve_set = 1'b0;
    serve_rst = 1'b0;
    if (state == IDLE) begin
      if (pend_set && pend_rst) begin
        if (RESET_PRIO == PRIO_RESET) serve_rst = 1'b1;
        else                          serve_set = 1'b1;
      end else if (pend_rst) begin
        serve_rst = 1'b1;
      end else if (pend_set) begin
        serve_set = 1'b1;
      end
    end
  end

  // An edge that finds its pending bit already set is merged into it, not re-queued.
  assign pend_set_nxt = (pend_set & ~serve_set) | (rise_set & ~pend_set);
  assign pend_rst_nxt = (pend_rst & ~serve_rst) | (rise_rst & ~pend_rst);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      pend_set   <= 1'b0;
      pend_rst   <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      shadow_q   <= 1'b0;
      conflict_q <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      pend_set   <= pend_set_nxt;
      pend_rst   <= pend_rst_nxt;
      s_q        <= serve_set;
      r_q        <= serve_rst;
      conflict_q <= (state == IDLE) && pend_set && pend_rst;
      dropped_q  <= (rise_set & pend_set) | (rise_rst & pend_rst);
      if (serve_set)      shadow_q <= 1'b1;
      else if (serve_rst) shadow_q <= 1'b0;

      case (state)
        IDLE: begin
          if (serve_set || serve_rst) begin
            state    <= HOLD;
            hold_cnt <= CNT_W'(GAP);
            busy_q   <= 1'b1;
          end else begin
            busy_q <= pend_set_nxt | pend_rst_nxt;
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt - 1'b1;
          // Leaving on the last count lets IDLE issue again exactly GAP+1 edges after the pulse.
          if (hold_cnt == CNT_W'(1)) begin
            state  <= IDLE;
            busy_q <= pend_set_nxt | pend_rst_nxt;
          end else begin
            busy_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= pend_set_nxt | pend_rst_nxt;
        end
      endcase
    end
  end

  assign bus.s        = s_q;
  assign bus.r        = r_q;
  assign bus.busy     = busy_q;
  assign bus.shadow_q = shadow_q;
  assign bus.conflict = conflict_q;
  assign bus.dropped  = dropped_q;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Scoreboard bench for sr_cmd_sequencer: three configurations share one pair of
// raw request lines and are compared every cycle against a behavioural model.
module tb_sr_cmd_sequencer;

  localparam int SYNC = 2;

  logic clk;
  logic clr;
  logic set_req;
  logic rst_req;

  int vectors;
  int miscompares;

  sr_cmd_sequencer_if bus_a ();
  sr_cmd_sequencer_if bus_b ();
  sr_cmd_sequencer_if bus_c ();

  assign bus_a.set_req = set_req;
  assign bus_a.rst_req = rst_req;
  assign bus_b.set_req = set_req;
  assign bus_b.rst_req = rst_req;
  assign bus_c.set_req = set_req;
  assign bus_c.rst_req = rst_req;

  sr_cmd_sequencer #(.SYNC_STAGES(2), .DEBOUNCE(4), .GAP(2), .RESET_PRIO(1'b1)) dut_a (
    .clk (clk), .clr (clr), .bus (bus_a)
  );
  sr_cmd_sequencer #(.SYNC_STAGES(2), .DEBOUNCE(4), .GAP(2), .RESET_PRIO(1'b0)) dut_b (
    .clk (clk), .clr (clr), .bus (bus_b)
  );
  sr_cmd_sequencer #(.SYNC_STAGES(2), .DEBOUNCE(1), .GAP(12), .RESET_PRIO(1'b1)) dut_c (
    .clk (clk), .clr (clr), .bus (bus_c)
  );

  // Output vector per instance: {s, r, busy, shadow_q, conflict, dropped}.
  logic [5:0] dut_out [3];
  assign dut_out[0] = {bus_a.s, bus_a.r, bus_a.busy, bus_a.shadow_q, bus_a.conflict, bus_a.dropped};
  assign dut_out[1] = {bus_b.s, bus_b.r, bus_b.busy, bus_b.shadow_q, bus_b.conflict, bus_b.dropped};
  assign dut_out[2] = {bus_c.s, bus_c.r, bus_c.busy, bus_c.shadow_q, bus_c.conflict, bus_c.dropped};

  function automatic int deb_of(input int m);
    return (m == 2) ? 1 : 4;
  endfunction

  function automatic int gap_of(input int m);
    return (m == 2) ? 12 : 2;
  endfunction

  function automatic bit prio_of(input int m);
    return (m != 1);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: raw lines become a delay line, then a run-length debounce,
  // then a queue of at most one outstanding request per type.
  bit line_q [2][$];
  bit lvl [3][2];
  int run [3][2];
  bit p_s [3];
  bit p_r [3];
  bit shd [3];
  int hold_left [3];
  logic [2:0][5:0] exp_q [$];

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      line_q[l].delete();
      repeat (SYNC) line_q[l].push_back(1'b0);
    end
    for (int m = 0; m < 3; m++) begin
      lvl[m][0] = 1'b0; lvl[m][1] = 1'b0;
      run[m][0] = 0;    run[m][1] = 0;
      p_s[m] = 1'b0; p_r[m] = 1'b0; shd[m] = 1'b0; hold_left[m] = 0;
    end
  endtask

  task automatic model_step();
    bit so [2];
    bit rz [3][2];
    bit is, ir, cf, dr;
    logic [2:0][5:0] ev;
    for (int l = 0; l < 2; l++) begin
      so[l] = line_q[l].pop_front();
      line_q[l].push_back((l == 0) ? set_req : rst_req);
    end
    for (int m = 0; m < 3; m++) begin
      for (int l = 0; l < 2; l++) begin
        rz[m][l] = 1'b0;
        if (so[l] != lvl[m][l]) begin
          run[m][l]++;
          if (run[m][l] == deb_of(m)) begin
            lvl[m][l] = so[l];
            run[m][l] = 0;
            rz[m][l]  = so[l];
          end
        end else begin
          run[m][l] = 0;
        end
      end
      is = 1'b0; ir = 1'b0; cf = 1'b0;
      if (hold_left[m] == 0) begin
        if (p_s[m] && p_r[m]) begin
          cf = 1'b1;
          if (prio_of(m)) ir = 1'b1; else is = 1'b1;
        end else if (p_s[m]) begin
          is = 1'b1;
        end else if (p_r[m]) begin
          ir = 1'b1;
        end
        if (is || ir) hold_left[m] = gap_of(m);
        if (is) shd[m] = 1'b1;
        if (ir) shd[m] = 1'b0;
      end else begin
        hold_left[m]--;
      end
      dr = (rz[m][0] & p_s[m]) | (rz[m][1] & p_r[m]);
      p_s[m] = is ? 1'b0 : (p_s[m] | rz[m][0]);
      p_r[m] = ir ? 1'b0 : (p_r[m] | rz[m][1]);
      ev[m] = {is, ir, (hold_left[m] != 0) | p_s[m] | p_r[m], shd[m], cf, dr};
    end
    exp_q.push_back(ev);
  endtask

  always @(negedge clr) begin
    model_reset();
    exp_q.delete();
    exp_q.push_back('0);
  end

  always @(posedge clk) begin
    if (!clr) begin
      model_reset();
      exp_q.delete();
      exp_q.push_back('0);
    end else begin
      model_step();
    end
  end

  // Monitor: pops one expected vector per cycle and checks invariants.
  int cyc;
  int last_pulse [3];
  bit last_valid [3];

  always @(negedge clk) begin
    logic [2:0][5:0] e;
    cyc++;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL scoreboard: no expected entry at cycle %0d", cyc);
    end else begin
      e = exp_q.pop_front();
      for (int m = 0; m < 3; m++) begin
        check_output($sformatf("out_dut%0d_cyc%0d", m, cyc), dut_out[m], e[m]);
        check_output($sformatf("s_and_r_dut%0d", m), dut_out[m][5] & dut_out[m][4], 0);
        if (!clr) begin
          last_valid[m] = 1'b0;
        end else if (dut_out[m][5] | dut_out[m][4]) begin
          if (last_valid[m])
            check_output($sformatf("gap_dut%0d_cyc%0d", m, cyc), (cyc - last_pulse[m]) >= (gap_of(m) + 1), 1);
          last_valid[m] = 1'b1;
          last_pulse[m] = cyc;
        end
      end
    end
  end

  task automatic apply_stimulus(input bit set_v, input bit rst_v, input int n_cycles);
    set_req = set_v;
    rst_req = rst_v;
    repeat (n_cycles) @(negedge clk);
  endtask

  task automatic reset_during(input int edge_n, input bit both_lines);
    int pulses;
    set_req = 1'b1;
    rst_req = both_lines;
    repeat (edge_n - 1) @(negedge clk);
    @(posedge clk);
    #2 clr = 1'b0;
    #1;
    for (int m = 0; m < 3; m++)
      check_output($sformatf("async_clr_e%0d_dut%0d", edge_n, m), dut_out[m], 0);
    set_req = 1'b0;
    rst_req = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      for (int m = 0; m < 3; m++)
        if (dut_out[m][5] | dut_out[m][4]) pulses++;
    end
    check_output($sformatf("stale_pulses_e%0d", edge_n), pulses, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int s_cnt, d_cnt;
    int hold_s, hold_r;
    bit pat;
    vectors = 0;
    miscompares = 0;
    clr = 1'b1;
    set_req = 1'b0;
    rst_req = 1'b0;
    #1 clr = 1'b0;
    @(negedge clk);
    for (int m = 0; m < 3; m++)
      check_output($sformatf("reset_state_dut%0d", m), dut_out[m], 0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    apply_stimulus(1'b0, 1'b0, 3);

    // Single set request held high: one pulse after edge 7.
    set_req = 1'b1;
    s_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check_output($sformatf("single_s_e%0d", k), bus_a.s, (k == 7));
      if (bus_a.s) s_cnt++;
      if (k == 7) check_output("single_shadow_e7", bus_a.shadow_q, 1);
    end
    check_output("single_pulse_count", s_cnt, 1);
    apply_stimulus(1'b0, 1'b0, 12);

    // Three-cycle glitch on rst_req is rejected by the default debouncer.
    rst_req = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 3) rst_req = 1'b0;
      check_output($sformatf("glitch_a_e%0d", k), {bus_a.r, bus_a.busy, bus_a.dropped}, 0);
      check_output($sformatf("glitch_b_e%0d", k), {bus_b.r, bus_b.busy, bus_b.dropped}, 0);
    end
    apply_stimulus(1'b0, 1'b0, 20);

    // Simultaneous requests: priority winner at edge 7, loser at edge 10.
    set_req = 1'b1;
    rst_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check_output($sformatf("simul_a_e%0d", k), {bus_a.s, bus_a.r, bus_a.conflict},
                   {29'd0, (k == 10), (k == 7), (k == 7)});
      check_output($sformatf("simul_b_e%0d", k), {bus_b.s, bus_b.r, bus_b.conflict},
                   {29'd0, (k == 7), (k == 10), (k == 7)});
    end
    check_output("simul_a_shadow", bus_a.shadow_q, 1);
    check_output("simul_b_shadow", bus_b.shadow_q, 0);
    apply_stimulus(1'b0, 1'b0, 25);

    // Merge on the fast-debounce, long-gap instance: two rises queue behind HOLD.
    s_cnt = 0;
    d_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      pat = (k <= 6) || (k == 9) || (k == 10) || (k == 13) || (k == 14);
      set_req = pat;
      @(negedge clk);
      if (bus_c.s) s_cnt++;
      if (bus_c.dropped) d_cnt++;
      if (k == 17) check_output("merge_s_e17", bus_c.s, 1);
    end
    check_output("merge_s_count", s_cnt, 2);
    check_output("merge_dropped_count", d_cnt, 1);
    apply_stimulus(1'b0, 1'b0, 25);

    // Asynchronous clear during the s cycle and during HOLD.
    reset_during(7, 1'b0);
    apply_stimulus(1'b0, 1'b0, 5);
    reset_during(8, 1'b1);
    apply_stimulus(1'b0, 1'b0, 5);

    // Random bouncing lines with occasional asynchronous clears.
    hold_s = 0;
    hold_r = 0;
    for (int i = 0; i < 2500; i++) begin
      if (hold_s == 0) begin
        set_req = 1'($urandom_range(0, 1));
        hold_s = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14);
      end
      if (hold_r == 0) begin
        rst_req = 1'($urandom_range(0, 1));
        hold_r = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14);
      end
      hold_s--;
      hold_r--;
      if ($urandom_range(0, 399) == 0) begin
        @(posedge clk);
        #2 clr = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    apply_stimulus(1'b0, 1'b0, 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
